up_counter_ctrl: RTL and testbench

UP_COUNTER_CTRL -- requirements
Module: up_counter_ctrl

---
 rtl/up_counter_ctrl.sv | 133 +++++++++++++
 tb/tb_up_counter_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/up_counter_ctrl.sv
// up_counter_ctrl
//   Run-controlled up counter. A START in IDLE latches a terminal count
//   (LIMIT) and a mode (MODE), then counts 0..limit repeatedly. In one-shot
//   mode it stops after one period; in periodic mode it keeps wrapping. STOP
//   aborts a run, PAUSE freezes it, and PERIODS counts completed periods,
//   saturating at 255. Every output comes from a register or is decoded from
//   registers only, so the outputs never follow the inputs combinationally.
//
// Ports
//   CLK      in   clock, all state changes on the rising edge
//   RST_N    in   asynchronous active-low reset
//   START    in   begin a run (only honoured in IDLE)
//   STOP     in   abort the run (highest priority)
//   PAUSE    in   level, freezes counting while high
//   MODE     in   0 = one-shot, 1 = periodic (sampled with START)
//   LIMIT    in   terminal count (sampled with START, 0 is rejected)
//   Q        out  current count
//   BUSY     out  high in RUN or PAUSED
//   TC       out  high in RUN while Q equals the latched limit
//   DONE     out  one-cycle pulse when a one-shot run completes
//   ERR      out  one-cycle pulse when START is rejected (LIMIT == 0)
//   PERIODS  out  number of completed periods, saturating at 255

module up_counter_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STOP,
  input  logic             PAUSE,
  input  logic             MODE,
  input  logic [WIDTH-1:0] LIMIT,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             TC,
  output logic             DONE,
  output logic             ERR,
  output logic [7:0]       PERIODS
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] lim_r;
  logic             mode_r;
  logic [7:0]       periods_r;
  logic             err_r;

  logic at_limit;
  assign at_limit = (count == lim_r);

  // Control FSM and datapath. The count returns to zero on the terminal
  // edge itself, so the one-cycle DONE state already shows Q = 0 and a
  // full-scale limit wraps naturally without relying on overflow.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      count     <= '0;
      lim_r     <= '0;
      mode_r    <= 1'b0;
      periods_r <= 8'd0;
      err_r     <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            if (LIMIT != '0) begin
              lim_r     <= LIMIT;
              mode_r    <= MODE;
              count     <= '0;
              periods_r <= 8'd0;
              state     <= S_RUN;
            end else begin
              err_r <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (STOP) begin
            count <= '0;
            state <= S_IDLE;
          end else if (PAUSE) begin
            state <= S_PAUSED;
          end else if (!at_limit) begin
            count <= count + 1'b1;
          end else begin
            count <= '0;
            if (periods_r != 8'hFF) begin
              periods_r <= periods_r + 8'd1;
            end
            if (!mode_r) begin
              state <= S_DONE;
            end
          end
        end

        // Leaving PAUSED costs one edge; counting resumes on the edge after.
        S_PAUSED: begin
          if (STOP) begin
            count <= '0;
            state <= S_IDLE;
          end else if (!PAUSE) begin
            state <= S_RUN;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from registered state only.
  assign Q       = count;
  assign BUSY    = (state == S_RUN) || (state == S_PAUSED);
  assign TC      = (state == S_RUN) && at_limit;
  assign DONE    = (state == S_DONE);
  assign ERR     = err_r;
  assign PERIODS = periods_r;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// tb_up_counter_ctrl
//   Scoreboard bench for up_counter_ctrl (WIDTH = 3). The stimulus process
//   drives one cycle of inputs just after each falling edge and queues the
//   outputs expected after the following rising edge; a monitor process pops
//   and compares one entry on every falling edge.

module tb_up_counter_ctrl;

  typedef struct packed {
    logic [2:0] q;
    logic       busy;
    logic       tc;
    logic       done;
    logic       err;
    logic [7:0] per;
  } exp_t;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       STOP;
  logic       PAUSE;
  logic       MODE;
  logic [2:0] LIMIT;
  logic [2:0] Q;
  logic       BUSY;
  logic       TC;
  logic       DONE;
  logic       ERR;
  logic [7:0] PERIODS;

  exp_t  exp_q[$];
  string name_q[$];
  int    vectors;
  int    miscompares;

  up_counter_ctrl #(.WIDTH(3)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .STOP    (STOP),
    .PAUSE   (PAUSE),
    .MODE    (MODE),
    .LIMIT   (LIMIT),
    .Q       (Q),
    .BUSY    (BUSY),
    .TC      (TC),
    .DONE    (DONE),
    .ERR     (ERR),
    .PERIODS (PERIODS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic [2:0] q, input logic busy,
                              input logic tc, input logic done,
                              input logic err, input logic [7:0] per);
    exp_t e;
    e.q    = q;
    e.busy = busy;
    e.tc   = tc;
    e.done = done;
    e.err  = err;
    e.per  = per;
    return e;
  endfunction

  // Compares the DUT outputs against one expected vector.
  task automatic checkOutput(input exp_t e, input string name);
    exp_t got;
    got = mk(Q, BUSY, TC, DONE, ERR, PERIODS);
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("[TB] FAIL %s: got q=%0d busy=%0b tc=%0b done=%0b err=%0b per=%0d, want q=%0d busy=%0b tc=%0b done=%0b err=%0b per=%0d",
               name, got.q, got.busy, got.tc, got.done, got.err, got.per,
               e.q, e.busy, e.tc, e.done, e.err, e.per);
    end
  endtask

  // One cycle of stimulus plus the outputs expected after the next edge.
  task automatic applyStimulus(input logic start, input logic stop,
                               input logic pause, input logic mode,
                               input logic [2:0] limit, input exp_t e,
                               input string name);
    @(negedge CLK);
    #1;
    START = start;
    STOP  = stop;
    PAUSE = pause;
    MODE  = mode;
    LIMIT = limit;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic idleCycle(input exp_t e, input string name);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, e, name);
  endtask

  // Monitor: the DUT presents a fresh output set every cycle.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checkOutput(e, n);
      end
    end
  end

  initial begin
    exp_t z;
    int   drain;
    vectors     = 0;
    miscompares = 0;
    RST_N = 1'b0;
    START = 1'b0;
    STOP  = 1'b0;
    PAUSE = 1'b0;
    MODE  = 1'b0;
    LIMIT = 3'd0;
    z = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    #1;
    checkOutput(z, "reset_state");
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
    exp_q.push_back(z);
    name_q.push_back("idle_after_reset");

    // One-shot, limit 5.
    applyStimulus(1, 0, 0, 0, 3'd5, mk(0, 1, 0, 0, 0, 0), "os5_start");
    for (int k = 1; k <= 5; k++)
      idleCycle(mk(3'(k), 1, (k == 5), 0, 0, 0), "os5_count");
    idleCycle(mk(0, 0, 0, 1, 0, 1), "os5_done");
    idleCycle(mk(0, 0, 0, 0, 0, 1), "os5_idle");

    // Periodic, limit 7 (full-scale wrap), then STOP.
    applyStimulus(1, 0, 0, 1, 3'd7, mk(0, 1, 0, 0, 0, 0), "per7_start");
    for (int k = 1; k <= 19; k++)
      idleCycle(mk(3'(k % 8), 1, ((k % 8) == 7), 0, 0, 8'(k / 8)), "per7_count");
    applyStimulus(0, 1, 0, 0, 3'd0, mk(0, 0, 0, 0, 0, 2), "per7_stop");
    idleCycle(mk(0, 0, 0, 0, 0, 2), "per7_idle");

    // Rejected START with LIMIT == 0.
    applyStimulus(1, 0, 0, 0, 3'd0, mk(0, 0, 0, 0, 1, 2), "err_pulse");
    idleCycle(mk(0, 0, 0, 0, 0, 2), "err_clear");

    // Limit 4, pause three cycles at the terminal count.
    applyStimulus(1, 0, 0, 0, 3'd4, mk(0, 1, 0, 0, 0, 0), "pause_start");
    for (int k = 1; k <= 4; k++)
      idleCycle(mk(3'(k), 1, (k == 4), 0, 0, 0), "pause_count");
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 0, 1, 0, 3'd0, mk(4, 1, 0, 0, 0, 0), "paused_hold");
    idleCycle(mk(4, 1, 1, 0, 0, 0), "pause_resume_tc");
    idleCycle(mk(0, 0, 0, 1, 0, 1), "pause_done");
    idleCycle(mk(0, 0, 0, 0, 0, 1), "pause_idle");

    // START during RUN with new LIMIT/MODE is ignored.
    applyStimulus(1, 0, 0, 0, 3'd5, mk(0, 1, 0, 0, 0, 0), "ign_start");
    idleCycle(mk(1, 1, 0, 0, 0, 0), "ign_count");
    applyStimulus(1, 0, 0, 1, 3'd2, mk(2, 1, 0, 0, 0, 0), "ign_restart");
    for (int k = 3; k <= 5; k++)
      idleCycle(mk(3'(k), 1, (k == 5), 0, 0, 0), "ign_count");
    idleCycle(mk(0, 0, 0, 1, 0, 1), "ign_done");
    idleCycle(mk(0, 0, 0, 0, 0, 1), "ign_idle");

    // STOP and PAUSE together at Q = 3.
    applyStimulus(1, 0, 0, 0, 3'd6, mk(0, 1, 0, 0, 0, 0), "sp_start");
    for (int k = 1; k <= 3; k++)
      idleCycle(mk(3'(k), 1, 0, 0, 0, 0), "sp_count");
    applyStimulus(0, 1, 1, 0, 3'd0, mk(0, 0, 0, 0, 0, 0), "sp_stop");
    idleCycle(mk(0, 0, 0, 0, 0, 0), "sp_idle");

    // Asynchronous reset mid-run at Q = 2.
    applyStimulus(1, 0, 0, 1, 3'd5, mk(0, 1, 0, 0, 0, 0), "rst_start");
    idleCycle(mk(1, 1, 0, 0, 0, 0), "rst_count");
    idleCycle(mk(2, 1, 0, 0, 0, 0), "rst_count");
    @(negedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    checkOutput(z, "async_reset");
    exp_q.push_back(z);
    name_q.push_back("reset_held");
    @(negedge CLK);
    #1;
    RST_N = 1'b1;
    exp_q.push_back(z);
    name_q.push_back("idle_after_midrun_reset");

    // Periodic limit 1 for 300+ periods: PERIODS saturates at 255.
    applyStimulus(1, 0, 0, 1, 3'd1, mk(0, 1, 0, 0, 0, 0), "sat_start");
    for (int k = 1; k <= 604; k++)
      idleCycle(mk(3'(k % 2), 1, ((k % 2) == 1), 0, 0,
                   (k / 2 > 255) ? 8'd255 : 8'(k / 2)), "sat_count");
    applyStimulus(0, 1, 0, 0, 3'd0, mk(0, 0, 0, 0, 0, 255), "sat_stop");

    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      @(posedge CLK);
      drain++;
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
